// File: rtl/csi_raw_pkg.sv
// rtl/csi_raw_pkg.sv - shared CSI-2 RAW data-type codes, group sizes and lane geometry
package csi_raw_pkg;

  // Full CSI-2 data-type codes
  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW12 = 8'h2C;
  localparam logic [7:0] DT_RAW14 = 8'h2D;

  // Low three bits of the data type, as seen on packet_type_i
  localparam logic [2:0] DT3_RAW10 = 3'h3;
  localparam logic [2:0] DT3_RAW12 = 3'h4;
  localparam logic [2:0] DT3_RAW14 = 3'h5;

  // Bytes produced per 4-pixel group
  localparam int G_RAW10 = 5;
  localparam int G_RAW12 = 6;
  localparam int G_RAW14 = 7;

  // PHY geometry: 8-bit gear, two lanes
  localparam int GEAR  = 8;
  localparam int LANES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH
  } state_t;

  // Group size for a 3-bit type code; unknown codes fall back to RAW14
  function automatic logic [2:0] group_size(input logic [2:0] dt);
    case (dt)
      DT3_RAW10: return 3'(G_RAW10);
      DT3_RAW12: return 3'(G_RAW12);
      default:   return 3'(G_RAW14);
    endcase
  endfunction

endpackage

// File: rtl/mipi_csi_raw_group_packer.sv
// rtl/mipi_csi_raw_group_packer.sv - packs four MSB-aligned pixels into one CSI-2 RAW byte group
module mipi_csi_raw_group_packer
  import csi_raw_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16
) (
  input  logic [4*PIXEL_WIDTH-1:0] pix_i,
  input  logic [2:0]               type_i,
  output logic [55:0]              group_o,
  output logic [2:0]               gsize_o
);

  logic [7:0] msb [4];
  logic [1:0] l10 [4];
  logic [3:0] l12 [4];
  logic [5:0] l14 [4];
  logic [23:0] w14;
  logic unused_pix;

  // Slice each pixel into its top byte and the LSB fields for each depth
  for (genvar i = 0; i < 4; i++) begin : g_pix
    assign msb[i] = pix_i[i*PIXEL_WIDTH + PIXEL_WIDTH - 1 -: 8];
    assign l10[i] = pix_i[i*PIXEL_WIDTH + PIXEL_WIDTH - 9 -: 2];
    assign l12[i] = pix_i[i*PIXEL_WIDTH + PIXEL_WIDTH - 9 -: 4];
    assign l14[i] = pix_i[i*PIXEL_WIDTH + PIXEL_WIDTH - 9 -: 6];
  end

  assign w14 = {l14[3], l14[2], l14[1], l14[0]};

  // Pixel LSBs below the selected depth are don't-care
  assign unused_pix = ^pix_i;

  // Byte 0 of the group sits at [7:0]; bytes beyond the group size stay zero
  always_comb begin
    group_o = '0;
    gsize_o = group_size(type_i);
    case (type_i)
      DT3_RAW10: group_o[39:0] = {l10[3], l10[2], l10[1], l10[0],
                                  msb[3], msb[2], msb[1], msb[0]};
      DT3_RAW12: group_o[47:0] = {l12[3], l12[2], msb[3], msb[2],
                                  l12[1], l12[0], msb[1], msb[0]};
      default:   group_o       = {w14, msb[3], msb[2], msb[1], msb[0]};
    endcase
  end

endmodule

// File: rtl/mipi_csi_tx_raw_packer_8b2lane.sv
// rtl/mipi_csi_tx_raw_packer_8b2lane.sv - RAW10/12/14 packer feeding a 2-lane 8-bit CSI-2 TX framer
module mipi_csi_tx_raw_packer_8b2lane
  import csi_raw_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int BUF_BYTES   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [2:0]               packet_type_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [4*PIXEL_WIDTH-1:0] in_data_i,
  input  logic                     in_last_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [GEAR*LANES-1:0]    out_data_o,
  output logic                     out_hi_valid_o,
  output logic                     out_last_o
);

  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam int BW = BUF_BYTES * 8;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(LANES);

  state_t          state_q, state_d;
  logic [2:0]      type_q, type_eff;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [55:0]     group;
  logic [2:0]      gsize;
  logic [CW-1:0]   drain_cnt, keep;
  logic [CW:0]     fill;
  logic            accept, xfer;

  // The first beat of a line uses the live type; later beats use the latched one
  assign type_eff = (state_q == ST_IDLE) ? packet_type_i : type_q;

  mipi_csi_raw_group_packer #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_group_packer (
    .pix_i   (in_data_i),
    .type_i  (type_eff),
    .group_o (group),
    .gsize_o (gsize)
  );

  assign accept = in_valid_i && in_ready_o;
  assign xfer   = out_valid_o && out_ready_i;

  // Bytes leaving this cycle: one word, or the lone byte of an odd tail
  always_comb begin
    drain_cnt = '0;
    if (xfer) drain_cnt = (cnt_q >= CNT_TWO) ? CNT_TWO : cnt_q;
  end

  assign keep = cnt_q - drain_cnt;
  assign fill = {1'b0, keep} + (CW+1)'(gsize);

  // Accept only if the whole group fits after this cycle's drain
  assign in_ready_o = !reset_i && (state_q != ST_FLUSH) && (fill <= (CW+1)'(BUF_BYTES));

  // Shift out drained bytes and append the new group right above what remains
  always_comb begin
    buf_d = buf_q >> {drain_cnt, 3'b000};
    cnt_d = keep;
    if (accept) begin
      buf_d = buf_d | (BW'(group) << {keep, 3'b000});
      cnt_d = keep + CW'(gsize);
    end
  end

  // Next state and register-derived output flags
  always_comb begin
    state_d        = state_q;
    out_valid_o    = (cnt_q >= CNT_TWO) || (state_q == ST_FLUSH && cnt_q == CNT_ONE);
    out_hi_valid_o = out_valid_o && (cnt_q >= CNT_TWO);
    out_last_o     = out_valid_o && (state_q == ST_FLUSH) && (cnt_q <= CNT_TWO);
    out_data_o     = buf_q[GEAR*LANES-1:0];
    case (state_q)
      ST_IDLE:   if (accept) state_d = in_last_i ? ST_FLUSH : ST_ACTIVE;
      ST_ACTIVE: if (accept && in_last_i) state_d = ST_FLUSH;
      ST_FLUSH:  if (xfer && cnt_q <= CNT_TWO) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, accumulator and type latch
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      type_q  <= DT3_RAW14;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      if (state_q == ST_IDLE && accept) type_q <= packet_type_i;
    end
  end

endmodule

// File: tb/tb_mipi_csi_tx_raw_packer_8b2lane.sv
// tb/tb_mipi_csi_tx_raw_packer_8b2lane.sv - directed self-checking bench for the RAW packer
module tb_mipi_csi_tx_raw_packer_8b2lane;

  logic        clk_i;
  logic        reset_i;
  logic [2:0]  packet_type_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] in_data_i;
  logic        in_last_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_hi_valid_o;
  logic        out_last_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] beat_data [16];
  logic        beat_last [16];
  logic [15:0] cap_data  [32];
  logic        cap_hi    [32];
  logic        cap_last  [32];
  int          cap_cyc   [32];
  int          acc_cyc   [16];
  int          ncap;
  int          nacc;
  bit          done;
  int          hold_changes;
  logic [15:0] hold_word;

  localparam logic [63:0] BEAT_RAW10 = {16'h5540, 16'hAA80, 16'h0040, 16'hFFC0};
  localparam logic [63:0] BEAT_RAW12 = {16'h7890, 16'h4560, 16'h1230, 16'hABC0};
  localparam logic [63:0] BEAT_RAW14 = {16'h0000, 16'h0000, 16'h0000, 16'hFFFC};
  localparam logic [63:0] BEAT_R14B  = {16'h4400, 16'h3300, 16'h2200, 16'h1100};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mipi_csi_tx_raw_packer_8b2lane #(
    .PIXEL_WIDTH(16),
    .BUF_BYTES(8)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .packet_type_i  (packet_type_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_hi_valid_o (out_hi_valid_o),
    .out_last_o     (out_last_o)
  );

  // Drives beats back to back and captures every transferred word; entered at posedge+1
  task automatic run_stream(input int nbeats, input int hold, input int max_cycles);
    int cyc;
    int bi;
    bit prev_v;
    logic [15:0] prev;
    ncap = 0; nacc = 0; done = 0; cyc = 0; hold_changes = 0;
    prev_v = 0; prev = '0; hold_word = '0;
    while (!done && cyc < max_cycles) begin
      bi = (nacc < 16) ? nacc : 15;
      in_valid_i  = (nacc < nbeats);
      in_data_i   = beat_data[bi];
      in_last_i   = beat_last[bi];
      out_ready_i = (cyc >= hold);
      @(negedge clk_i);
      if (!out_ready_i && out_valid_o) begin
        if (prev_v && out_data_o !== prev) hold_changes++;
        prev = out_data_o; prev_v = 1; hold_word = out_data_o;
      end
      if (in_valid_i && in_ready_o) begin
        acc_cyc[bi] = cyc;
        nacc++;
      end
      if (out_valid_o && out_ready_i) begin
        if (ncap < 32) begin
          cap_data[ncap] = out_data_o;
          cap_hi[ncap]   = out_hi_valid_o;
          cap_last[ncap] = out_last_o;
          cap_cyc[ncap]  = cyc;
        end
        ncap++;
        if (out_last_o) done = 1;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    in_valid_i = 0; in_last_i = 0; out_ready_i = 1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL stream_timeout: last word not seen within %0d cycles", max_cycles);
    end
  endtask

  task automatic test_reset();
    reset_i = 1; packet_type_i = 3'h3; in_valid_i = 0; in_data_i = '0;
    in_last_i = 0; out_ready_i = 1;
    #2;
    total++;
    if ({out_valid_o, out_hi_valid_o, out_last_o, in_ready_o, out_data_o} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b hi=%b last=%b rdy=%b data=%h, want all 0",
               out_valid_o, out_hi_valid_o, out_last_o, in_ready_o, out_data_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 0;
    @(negedge clk_i);
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got rdy=%b v=%b, want rdy=1 v=0", in_ready_o, out_valid_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_raw10_single();
    logic [15:0] exp_w [3];
    exp_w = '{16'h00FF, 16'h55AA, 16'h0067};
    packet_type_i = 3'h3;
    beat_data[0] = BEAT_RAW10; beat_last[0] = 1;
    run_stream(1, 0, 20);
    total++;
    if (ncap !== 3) begin
      bad++; $display("FAIL raw10_count: got %0d words, want 3", ncap);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cap_data[k] !== exp_w[k] || cap_hi[k] !== (k < 2) || cap_last[k] !== (k == 2)) begin
        bad++;
        $display("FAIL raw10_word%0d: got %h hi=%b last=%b, want %h hi=%b last=%b",
                 k, cap_data[k], cap_hi[k], cap_last[k], exp_w[k], k < 2, k == 2);
      end
    end
    total++;
    if (cap_cyc[0] !== 1) begin
      bad++; $display("FAIL raw10_latency: first word at cycle %0d, want 1", cap_cyc[0]);
    end
    @(negedge clk_i);
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL raw10_idle: got v=%b rdy=%b, want v=0 rdy=1", out_valid_o, in_ready_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_raw12_single();
    logic [15:0] exp_w [3];
    exp_w = '{16'h12AB, 16'h453C, 16'h9678};
    packet_type_i = 3'h4;
    beat_data[0] = BEAT_RAW12; beat_last[0] = 1;
    run_stream(1, 0, 20);
    total++;
    if (ncap !== 3) begin
      bad++; $display("FAIL raw12_count: got %0d words, want 3", ncap);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cap_data[k] !== exp_w[k] || cap_hi[k] !== 1'b1 || cap_last[k] !== (k == 2)) begin
        bad++;
        $display("FAIL raw12_word%0d: got %h hi=%b last=%b, want %h hi=1 last=%b",
                 k, cap_data[k], cap_hi[k], cap_last[k], exp_w[k], k == 2);
      end
    end
  endtask

  task automatic test_raw14_single();
    logic [15:0] exp_w [4];
    exp_w = '{16'h00FF, 16'h0000, 16'h003F, 16'h0000};
    packet_type_i = 3'h5;
    beat_data[0] = BEAT_RAW14; beat_last[0] = 1;
    run_stream(1, 0, 20);
    total++;
    if (ncap !== 4) begin
      bad++; $display("FAIL raw14_count: got %0d words, want 4", ncap);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (cap_data[k] !== exp_w[k] || cap_hi[k] !== (k < 3) || cap_last[k] !== (k == 3)) begin
        bad++;
        $display("FAIL raw14_word%0d: got %h hi=%b last=%b, want %h hi=%b last=%b",
                 k, cap_data[k], cap_hi[k], cap_last[k], exp_w[k], k < 3, k == 3);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp5 [5];
    int exp_acc [8];
    int gaps;
    exp5    = '{16'h00FF, 16'h55AA, 16'hFF67, 16'hAA00, 16'h6755};
    exp_acc = '{0, 1, 4, 6, 9, 11, 14, 16};
    packet_type_i = 3'h3;
    for (int b = 0; b < 8; b++) begin
      beat_data[b] = BEAT_RAW10;
      beat_last[b] = (b == 7);
    end
    run_stream(8, 0, 60);
    total++;
    if (ncap !== 20) begin
      bad++; $display("FAIL b2b_count: got %0d words, want 20", ncap);
    end
    for (int k = 0; k < 20; k++) begin
      total++;
      if (cap_data[k] !== exp5[k % 5] || cap_hi[k] !== 1'b1 || cap_last[k] !== (k == 19)) begin
        bad++;
        $display("FAIL b2b_word%0d: got %h hi=%b last=%b, want %h hi=1 last=%b",
                 k, cap_data[k], cap_hi[k], cap_last[k], exp5[k % 5], k == 19);
      end
    end
    gaps = 0;
    for (int k = 0; k < 20; k++) if (cap_cyc[k] !== k + 1) gaps++;
    total++;
    if (gaps !== 0) begin
      bad++; $display("FAIL b2b_gaps: got %0d misplaced words, want 0", gaps);
    end
    for (int b = 0; b < 8; b++) begin
      total++;
      if (acc_cyc[b] !== exp_acc[b]) begin
        bad++; $display("FAIL b2b_accept%0d: got cycle %0d, want %0d", b, acc_cyc[b], exp_acc[b]);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_w [7];
    exp_w = '{16'h00FF, 16'h0000, 16'h003F, 16'h1100, 16'h3322, 16'h0044, 16'h0000};
    packet_type_i = 3'h5;
    beat_data[0] = BEAT_RAW14; beat_last[0] = 0;
    beat_data[1] = BEAT_R14B;  beat_last[1] = 1;
    run_stream(2, 10, 40);
    total++;
    if (acc_cyc[0] !== 0 || acc_cyc[1] !== 12) begin
      bad++; $display("FAIL bp_accept: got cycles %0d,%0d, want 0,12", acc_cyc[0], acc_cyc[1]);
    end
    total++;
    if (hold_changes !== 0 || hold_word !== 16'h00FF) begin
      bad++; $display("FAIL bp_hold: got %0d changes word=%h, want 0 changes word=00ff",
                      hold_changes, hold_word);
    end
    total++;
    if (ncap !== 7) begin
      bad++; $display("FAIL bp_count: got %0d words, want 7", ncap);
    end
    for (int k = 0; k < 7; k++) begin
      total++;
      if (cap_data[k] !== exp_w[k] || cap_hi[k] !== 1'b1 || cap_last[k] !== (k == 6)) begin
        bad++;
        $display("FAIL bp_word%0d: got %h hi=%b last=%b, want %h hi=1 last=%b",
                 k, cap_data[k], cap_hi[k], cap_last[k], exp_w[k], k == 6);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_midline();
    logic [15:0] exp_w [3];
    exp_w = '{16'h12AB, 16'h453C, 16'h9678};
    packet_type_i = 3'h3; in_data_i = BEAT_RAW10; in_last_i = 0;
    in_valid_i = 1; out_ready_i = 0;
    @(posedge clk_i); #1;
    in_valid_i = 0;
    @(negedge clk_i);
    total++;
    if (out_valid_o !== 1'b1 || out_data_o !== 16'h00FF) begin
      bad++; $display("FAIL midline_pre: got v=%b data=%h, want v=1 data=00ff", out_valid_o, out_data_o);
    end
    #2 reset_i = 1;
    #1;
    total++;
    if ({out_valid_o, out_hi_valid_o, out_last_o, in_ready_o, out_data_o} !== 20'h0) begin
      bad++;
      $display("FAIL midline_async: got v=%b hi=%b last=%b rdy=%b data=%h, want all 0",
               out_valid_o, out_hi_valid_o, out_last_o, in_ready_o, out_data_o);
    end
    @(posedge clk_i); #1;
    reset_i = 0; out_ready_i = 1;
    @(negedge clk_i);
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL midline_idle: got v=%b rdy=%b, want v=0 rdy=1", out_valid_o, in_ready_o);
    end
    @(posedge clk_i); #1;
    packet_type_i = 3'h4;
    beat_data[0] = BEAT_RAW12; beat_last[0] = 1;
    run_stream(1, 0, 20);
    total++;
    if (ncap !== 3) begin
      bad++; $display("FAIL midline_count: got %0d words, want 3", ncap);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (cap_data[k] !== exp_w[k] || cap_last[k] !== (k == 2)) begin
        bad++;
        $display("FAIL midline_word%0d: got %h last=%b, want %h last=%b",
                 k, cap_data[k], cap_last[k], exp_w[k], k == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw10_single();
    test_raw12_single();
    test_raw14_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mipi_csi_tx_raw_packer_8b2lane.md
Name: mipi_csi_tx_raw_packer_8b2lane

Overview:
Transmit-side RAW packer for the 2-lane, 8-bit-gear MIPI CSI-2 TX path. It accepts 4 MSB-aligned pixels per beat and packs them into the CSI-2 RAW10, RAW12 or RAW14 byte order. It emits 2 bytes per clock (lane 0 = bits [7:0], lane 1 = bits [15:8]) toward the TX packet framer. A byte-accumulator buffer absorbs the rate mismatch: 5, 6 or 7 bytes per beat in, 2 bytes per clock out.

Parameters:
PIXEL_WIDTH, 16, width of each input pixel slot; pixel data is MSB-aligned, unused LSBs are ignored.
BUF_BYTES, 8, accumulator capacity in bytes; must be at least 8.

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
packet_type_i  in  3  data type [2:0]: 3'h3 = RAW10 (0x2B), 3'h4 = RAW12 (0x2C), anything else = RAW14
in_valid_i  in  1  pixel beat valid
in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o
in_data_i  in  4*PIXEL_WIDTH  pixels P0..P3; P0 at [PIXEL_WIDTH-1:0] (first on wire)
in_last_i  in  1  final beat of the line
out_valid_o  out  1  output word valid
out_ready_i  in  1  downstream accepts the word
out_data_o  out  16  [7:0] = earlier byte (lane 0), [15:8] = next byte (lane 1)
out_hi_valid_o  out  1  [15:8] holds a valid byte; 0 only on an odd final word
out_last_o  out  1  word is the final word of the line

Behaviour:
- Group size G = 5 (RAW10), 6 (RAW12), 7 (RAW14), taken from the latched type.
- Byte order, N = bit depth, Px[msb] = Px[PIXEL_WIDTH-1 -: 8]:
  - RAW10: P0m, P1m, P2m, P3m, {P3[1:0], P2[1:0], P1[1:0], P0[1:0]}.
  - RAW12: P0m, P1m, {P1[3:0], P0[3:0]}, P2m, P3m, {P3[3:0], P2[3:0]}.
  - RAW14: P0m..P3m, then the 24-bit word {P3[5:0], P2[5:0], P1[5:0], P0[5:0]} as 3 bytes, LS byte first.
  - LSBs are taken as Px[PIXEL_WIDTH-9 -: N-8].
- State machine:
  - IDLE -> ACTIVE: on the first accepted beat; packet_type_i is latched on that beat.
  - ACTIVE -> FLUSH: when a beat with in_last_i is accepted; also IDLE -> FLUSH directly if the first beat has in_last_i.
  - FLUSH -> IDLE: on the transfer that empties the buffer.
  - packet_type_i is ignored outside IDLE.
- Buffer: byte count cnt in 0..BUF_BYTES; bytes leave from the low end.
- out_valid_o = (cnt >= 2) || (state == FLUSH && cnt == 1); it is register-derived with no combinational path from inputs.
- Odd final word: cnt == 1 in FLUSH gives out_data_o[15:8] = 0 and out_hi_valid_o = 0. In ACTIVE with cnt == 1 there is no output; the block waits for more input.
- out_last_o = out_valid_o && state == FLUSH && cnt <= 2.
- Output transfer removes min(cnt, 2) bytes. out_data_o and the flags hold stable while out_valid_o && !out_ready_i.
- in_ready_o = !reset_i && state != FLUSH && (cnt - drain + G <= BUF_BYTES), where drain = 2 if an output transfer occurs this cycle, else 0. This is a combinational path from out_ready_i.
- Simultaneous accept and transfer: cnt_next = cnt - drain + G. Appended bytes land directly above the remaining bytes.
- Latency: bytes of a beat accepted in cycle N are first visible on out_data_o in N+1 (if they are at the buffer head).
- Sustained throughput with out_ready_i = 1: RAW10 2 beats per 5 clocks, RAW12 1 per 3, RAW14 2 per 7.
- Reset, including mid-line: state = IDLE, cnt = 0, out_valid_o = 0, out_data_o = 0, out_hi_valid_o = 0, out_last_o = 0, in_ready_o = 0 while reset_i is high. Buffered bytes are discarded.

Decomposition:
- Shared package csi_raw_pkg, holding:
  - data-type codes RAW10 / RAW12 / RAW14 (full 8-bit and [2:0] forms);
  - group-size constants 5 / 6 / 7;
  - GEAR = 8 and LANES = 2.
- One sub-module, mipi_csi_raw_group_packer: combinational; pixels plus type in, 56-bit byte group plus G out.
- The top module holds the accumulator, count and FSM.

Test Plan:
1. RAW10, single beat {P3..P0} = {16'h5540, 16'hAA80, 16'h0040, 16'hFFC0}, last = 1, out_ready_i = 1 -> words 16'h00FF, 16'h55AA, then 16'h0067 with hi_valid = 0 and last = 1; then IDLE.
2. RAW12, single beat of pixels 12'h789/456/123/ABC (P3..P0, MSB-aligned), last -> words 16'h12AB, 16'h453C, 16'h9678 (last, hi_valid = 1).
3. RAW14, single beat P0 = 16'hFFFC, P1..P3 = 0, last -> 16'h00FF, 16'h0000, 16'h003F, then 16'h0000 with hi_valid = 0 and last.
4. RAW10, 8 continuous beats, out_ready_i = 1 -> exactly 20 words with no gaps after the first; in_ready_o high 2 of every 5 cycles; the last word carries last with hi_valid = 1.
5. Backpressure: RAW14, out_ready_i = 0 for 10 cycles -> one beat accepted, then in_ready_o = 0; out_data_o holds 16'h00FF; after release the stream is correct and complete.
6. reset_i pulsed mid-line (cnt = 5) -> all outputs 0 immediately (async); after release a new RAW12 line packs correctly with no stale bytes.
